// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master that runs one {we, addr[6:0]} command
// byte plus one data byte per host request, matching the frame format of the
// SPI-to-Wishbone slave bridge. Read data is returned with a one-cycle done_o.
// Build option: define SPI_MASTER_QUEUE_EN to add a one-entry pending request
// slot, so a request can be taken while a frame is still running.
module spi_master_ctrl #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned GAP_CYC = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       req_we_i,
    input  logic [6:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       req_rdy_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_ss
);

    localparam int unsigned CNT_MAX = (GAP_CYC > 2 * CLK_DIV) ? GAP_CYC : 2 * CLK_DIV;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    // SS_SETUP loads CLK_DIV (not CLK_DIV-1): the first cycle after acceptance
    // still has ss high, then ss is low for CLK_DIV cycles before the first rise.
    localparam logic [CW-1:0] SETUP_LD = CW'(CLK_DIV);
    localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SSI_LD   = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, SS_SETUP, SHIFT_CMD, GAP, SHIFT_DATA, SS_HOLD, SS_IDLE, DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [15:0]   tx_q;
    logic [7:0]    rx_q;
    logic          we_q;
    logic          ss_q;
    logic          sck_q;
    logic          mosi_q;
    logic          busy_q;
    logic          done_q;
    logic          rdy_q;
    logic [7:0]    rd_data_q;

`ifdef SPI_MASTER_QUEUE_EN
    logic          pend_valid_q;
    logic [15:0]   pend_frame_q;
`endif

    logic          accept_d;
    logic          launch_d;
    logic [15:0]   req_frame_d;
    logic [15:0]   frame_d;

    // Request acceptance and selection of the frame to launch next
    always_comb begin
        accept_d    = req_i && rdy_q;
        req_frame_d = {req_we_i, req_addr_i, req_we_i ? req_data_i : 8'h00};
        frame_d     = req_frame_d;
        launch_d    = (state_q == IDLE) && accept_d;
`ifdef SPI_MASTER_QUEUE_EN
        if (pend_valid_q) begin
            frame_d  = pend_frame_q;
            launch_d = (state_q == IDLE) || (state_q == DONE);
        end
`endif
    end

    // Frame sequencer: phase timing, shift registers and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            we_q      <= 1'b0;
            ss_q      <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b1;
            rd_data_q <= '0;
`ifdef SPI_MASTER_QUEUE_EN
            pend_valid_q <= 1'b0;
            pend_frame_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            case (state_q)
                IDLE, DONE: begin
                    if (launch_d) begin
                        state_q <= SS_SETUP;
                        cnt_q   <= SETUP_LD;
                        tx_q    <= frame_d;
                        we_q    <= frame_d[15];
                        bit_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`ifndef SPI_MASTER_QUEUE_EN
                    rdy_q <= !launch_d;
`endif
                end
                SS_SETUP: begin
                    ss_q   <= 1'b0;
                    mosi_q <= tx_q[15];
                    if (cnt_q == '0) begin
                        state_q <= SHIFT_CMD;
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], spi_miso};
                        cnt_q   <= HALF_LD;
                    end
                end
                SHIFT_CMD, SHIFT_DATA: begin
                    if (cnt_q == '0) begin
                        if (sck_q) begin
                            sck_q  <= 1'b0;
                            tx_q   <= {tx_q[14:0], 1'b0};
                            mosi_q <= tx_q[14];
                            cnt_q  <= HALF_LD;
                        end else if (bit_q == 3'd7) begin
                            bit_q <= '0;
                            if (state_q == SHIFT_CMD) begin
                                state_q <= GAP;
                                cnt_q   <= GAP_LD;
                                rx_q    <= '0;
                            end else begin
                                state_q <= SS_HOLD;
                                cnt_q   <= HALF_LD;
                            end
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            sck_q <= 1'b1;
                            rx_q  <= {rx_q[6:0], spi_miso};
                            cnt_q <= HALF_LD;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= SHIFT_DATA;
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], spi_miso};
                        cnt_q   <= HALF_LD;
                    end
                end
                SS_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= SS_IDLE;
                        ss_q    <= 1'b1;
                        cnt_q   <= SSI_LD;
                    end
                end
                SS_IDLE: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        if (!we_q) rd_data_q <= rx_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef SPI_MASTER_QUEUE_EN
            // A request that cannot start immediately waits in the slot;
            // the slot only accepts when empty, so store and take never collide.
            if (accept_d && (state_q != IDLE)) begin
                pend_valid_q <= 1'b1;
                pend_frame_q <= req_frame_d;
                rdy_q        <= 1'b0;
            end else if (pend_valid_q && launch_d) begin
                pend_valid_q <= 1'b0;
                rdy_q        <= 1'b1;
            end
`endif
        end
    end

    assign req_rdy_o = rdy_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign rd_data_o = rd_data_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_ss    = ss_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a bus monitor plus mode-0 slave
// model (register file behind the SPI bridge) and randomized requests checked
// against frame-level expectations derived from the frame format and timing.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 4;
    localparam int GAP_CYC = 16;
    localparam int LAT     = 1 + CLK_DIV + 16 * CLK_DIV + GAP_CYC + 16 * CLK_DIV + CLK_DIV + 2 * CLK_DIV;
    localparam int SS_LOW  = CLK_DIV + 16 * CLK_DIV + GAP_CYC + 16 * CLK_DIV + CLK_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_i = 1'b0;
    logic       req_we_i = 1'b0;
    logic [6:0] req_addr_i = '0;
    logic [7:0] req_data_i = '0;
    logic       req_rdy_o, busy_o, done_o;
    logic [7:0] rd_data_o;
    logic       spi_sck, spi_mosi, spi_ss;
    logic       spi_miso = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_rdy_o(req_rdy_o),
        .busy_o(busy_o), .done_o(done_o), .rd_data_o(rd_data_o), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_ss(spi_ss)
    );

    // Reference register file and last read value
    logic [7:0] model_mem [128];
    logic [7:0] model_rd = 8'h00;

    // Bus monitor / slave state (written only by the monitor process)
    logic [7:0]  slave_mem [128];
    logic        sl_init = 1'b0;
    logic        prev_ss = 1'b1, prev_sck = 1'b0;
    int          lo_run = 0, hi_run = 0, fr_low = 0, fr_rises = 0, fr_bad = 0, fr_pre_high = 0;
    int          ss_hi_run = 0, idle_sck_bad = 0;
    logic [15:0] fr_bits = '0;
    logic [7:0]  sl_tx = '0;
    int          last_low = 0, last_rises = 0, last_bad = 0, last_pre_high = 0;
    logic [15:0] last_bits = '0;
    int          frames_seen = 0, dones_seen = 0;

    function automatic logic [7:0] init_val(input int a);
        return 8'(a * 73 + 90);
    endfunction

    // Monitor and slave: sample the bus on the falling clk edge
    always @(negedge clk) begin
        if (!sl_init) begin
            for (int i = 0; i < 128; i++) slave_mem[i] = init_val(i);
            sl_init = 1'b1;
        end
        if (done_o === 1'b1) dones_seen++;
        if (spi_ss === 1'b1) begin
            if (prev_ss === 1'b0) begin
                last_low = fr_low; last_rises = fr_rises; last_bits = fr_bits;
                last_bad = fr_bad + ((lo_run != 2 * CLK_DIV) ? 1 : 0);
                last_pre_high = fr_pre_high;
                frames_seen++;
                ss_hi_run = 0;
            end
            if (spi_sck !== 1'b0) idle_sck_bad++;
            ss_hi_run++;
            spi_miso = 1'b0;
        end else if (spi_ss === 1'b0) begin
            if (prev_ss === 1'b1) begin
                fr_low = 0; fr_rises = 0; fr_bad = 0; fr_bits = '0;
                fr_pre_high = ss_hi_run; lo_run = 0; hi_run = 0;
                sl_tx = 8'($urandom);
                spi_miso = sl_tx[7];
            end
            fr_low++;
            if (spi_sck && !prev_sck) begin
                if (lo_run != ((fr_rises == 8) ? CLK_DIV + GAP_CYC : CLK_DIV)) fr_bad++;
                fr_rises++;
                fr_bits = {fr_bits[14:0], spi_mosi};
                hi_run = 0;
                if (fr_rises == 16 && fr_bits[15]) slave_mem[fr_bits[14:8]] = fr_bits[7:0];
            end
            if (!spi_sck && prev_sck) begin
                if (hi_run != CLK_DIV) fr_bad++;
                lo_run = 0;
                if (fr_rises == 8) sl_tx = fr_bits[7] ? 8'($urandom) : slave_mem[fr_bits[6:0]];
                else sl_tx = {sl_tx[6:0], 1'b0};
                spi_miso = sl_tx[7];
            end
            if (spi_sck) hi_run++; else lo_run++;
        end
        prev_ss = spi_ss;
        prev_sck = spi_sck;
    end

    // Drive one request and wait (bounded) for its done pulse
    task automatic issue(input logic we, input logic [6:0] addr, input logic [7:0] data,
                         output int lat, output logic [7:0] rd_at_done, output logic busy_after);
        int guard;
        guard = 0;
        @(negedge clk);
        while (req_rdy_o !== 1'b1 && guard < 1000) begin @(negedge clk); guard++; end
        req_i = 1'b1; req_we_i = we; req_addr_i = addr; req_data_i = data;
        @(posedge clk); #1; req_i = 1'b0;
        lat = -1; rd_at_done = 8'hxx;
        for (int n = 1; n <= LAT + 200; n++) begin
            @(posedge clk); #1;
            if (done_o === 1'b1) begin lat = n; rd_at_done = rd_data_o; break; end
        end
        @(posedge clk); #1;
        busy_after = busy_o;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (spi_ss !== 1'b1) begin tests_failed++; $display("FAIL reset_ss: got %b want 1", spi_ss); end
        tests_run++; if (spi_sck !== 1'b0) begin tests_failed++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
        tests_run++; if (spi_mosi !== 1'b0) begin tests_failed++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_o); end
        tests_run++; if (rd_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_rd: got %h want 00", rd_data_o); end
        tests_run++; if (req_rdy_o !== 1'b1) begin tests_failed++; $display("FAIL reset_rdy: got %b want 1", req_rdy_o); end
        @(negedge clk); reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_directed();
        int lat; logic [7:0] rdv; logic bz;
        issue(1'b1, 7'h12, 8'hA5, lat, rdv, bz);
        model_mem[7'h12] = 8'hA5;
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
        tests_run++; if (last_bits !== 16'h92A5) begin tests_failed++; $display("FAIL wr_mosi: got %h want 92a5", last_bits); end
        tests_run++; if (last_low != SS_LOW) begin tests_failed++; $display("FAIL wr_ss_low: got %0d want %0d", last_low, SS_LOW); end
        tests_run++; if (last_rises != 16) begin tests_failed++; $display("FAIL wr_sck_rises: got %0d want 16", last_rises); end
        tests_run++; if (last_bad != 0) begin tests_failed++; $display("FAIL wr_sck_timing: got %0d bad phases want 0", last_bad); end
        tests_run++; if (rdv !== 8'h00) begin tests_failed++; $display("FAIL wr_rd_unchanged: got %h want 00", rdv); end
        tests_run++; if (bz !== 1'b0) begin tests_failed++; $display("FAIL wr_busy_drop: got %b want 0", bz); end
    endtask

    task automatic test_read_directed();
        int lat; logic [7:0] rdv; logic bz;
        issue(1'b1, 7'h05, 8'h3C, lat, rdv, bz);
        model_mem[7'h05] = 8'h3C;
        issue(1'b0, 7'h05, 8'hFF, lat, rdv, bz);
        model_rd = 8'h3C;
        tests_run++; if (last_bits !== 16'h0500) begin tests_failed++; $display("FAIL rd_mosi: got %h want 0500", last_bits); end
        tests_run++; if (rdv !== 8'h3C) begin tests_failed++; $display("FAIL rd_data: got %h want 3c", rdv); end
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
    endtask

    task automatic test_random();
        int lat; logic [7:0] rdv; logic bz;
        logic we; logic [6:0] addr; logic [7:0] data, exp_rd; logic [15:0] exp_bits;
        for (int i = 0; i < 14; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = (i == 0) ? 7'h00 : (i == 1) ? 7'h7F : 7'($urandom);
            data = (i == 2) ? 8'hFF : (i == 3) ? 8'h00 : 8'($urandom);
            if (i == 4) begin we = 1'b0; addr = 7'h7F; end
            exp_bits = {we, addr, we ? data : 8'h00};
            exp_rd   = we ? model_rd : model_mem[addr];
            issue(we, addr, data, lat, rdv, bz);
            if (we) model_mem[addr] = data; else model_rd = model_mem[addr];
            tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, LAT); end
            tests_run++; if (last_bits !== exp_bits) begin tests_failed++; $display("FAIL rnd%0d_mosi: got %h want %h", i, last_bits, exp_bits); end
            tests_run++; if (rdv !== exp_rd) begin tests_failed++; $display("FAIL rnd%0d_rd_data: got %h want %h", i, rdv, exp_rd); end
            tests_run++; if (last_low != SS_LOW) begin tests_failed++; $display("FAIL rnd%0d_ss_low: got %0d want %0d", i, last_low, SS_LOW); end
            tests_run++; if (last_bad != 0 || last_rises != 16) begin tests_failed++; $display("FAIL rnd%0d_sck: got %0d bad, %0d rises want 0, 16", i, last_bad, last_rises); end
            tests_run++; if (bz !== 1'b0) begin tests_failed++; $display("FAIL rnd%0d_busy_drop: got %b want 0", i, bz); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, lat; logic [7:0] rdv; logic bz;
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h33; req_data_i = 8'h5A;
        @(posedge clk); #1; req_i = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk); reset = 1'b1; d0 = dones_seen;
        @(posedge clk); #1;
        tests_run++; if (spi_ss !== 1'b1) begin tests_failed++; $display("FAIL abort_ss: got %b want 1", spi_ss); end
        tests_run++; if (spi_sck !== 1'b0) begin tests_failed++; $display("FAIL abort_sck: got %b want 0", spi_sck); end
        tests_run++; if (spi_mosi !== 1'b0) begin tests_failed++; $display("FAIL abort_mosi: got %b want 0", spi_mosi); end
        tests_run++; if (busy_o !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b want 0", busy_o); end
        tests_run++; if (rd_data_o !== 8'h00) begin tests_failed++; $display("FAIL abort_rd: got %h want 00", rd_data_o); end
        @(negedge clk); reset = 1'b0;
        model_rd = 8'h00;
        repeat (LAT + 20) @(posedge clk);
        tests_run++; if (dones_seen != d0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses want 0", dones_seen - d0); end
        issue(1'b0, 7'h12, 8'h00, lat, rdv, bz);
        model_rd = model_mem[7'h12];
        tests_run++; if (lat != LAT) begin tests_failed++; $display("FAIL post_abort_latency: got %0d want %0d", lat, LAT); end
        tests_run++; if (last_bits !== 16'h1200 || last_bad != 0) begin tests_failed++; $display("FAIL post_abort_frame: got %h/%0d want 1200/0", last_bits, last_bad); end
        tests_run++; if (rdv !== model_mem[7'h12]) begin tests_failed++; $display("FAIL post_abort_rd: got %h want %h", rdv, model_mem[7'h12]); end
    endtask

`ifdef SPI_MASTER_QUEUE_EN
    task automatic test_queue();
        int d0, n; logic [7:0] rdv;
        d0 = dones_seen;
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h20; req_data_i = 8'h11;
        @(posedge clk); #1; req_i = 1'b0;
        model_mem[7'h20] = 8'h11;
        repeat (10) @(posedge clk);
        #1;
        tests_run++; if (req_rdy_o !== 1'b1 || busy_o !== 1'b1) begin tests_failed++; $display("FAIL q_rdy_busy: got %b/%b want 1/1", req_rdy_o, busy_o); end
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b0; req_addr_i = 7'h01;
        @(posedge clk); #1; req_i = 1'b0;
        tests_run++; if (req_rdy_o !== 1'b0) begin tests_failed++; $display("FAIL q_slot_full: got %b want 0", req_rdy_o); end
        n = 0;
        while (done_o !== 1'b1 && n < LAT + 50) begin @(posedge clk); #1; n++; end
        tests_run++; if (rd_data_o !== model_rd) begin tests_failed++; $display("FAIL q_first_rd: got %h want %h", rd_data_o, model_rd); end
        @(posedge clk); #1;
        tests_run++; if (busy_o !== 1'b1 || req_rdy_o !== 1'b1) begin tests_failed++; $display("FAIL q_launch: got %b/%b want 1/1", busy_o, req_rdy_o); end
        n = 0;
        while (done_o !== 1'b1 && n < LAT + 50) begin @(posedge clk); #1; n++; end
        rdv = rd_data_o;
        model_rd = model_mem[7'h01];
        tests_run++; if (rdv !== model_mem[7'h01]) begin tests_failed++; $display("FAIL q_second_rd: got %h want %h", rdv, model_mem[7'h01]); end
        tests_run++; if (last_pre_high < 2 * CLK_DIV) begin tests_failed++; $display("FAIL q_ss_high: got %0d want >= %0d", last_pre_high, 2 * CLK_DIV); end
        tests_run++; if (last_bits !== 16'h0100) begin tests_failed++; $display("FAIL q_second_mosi: got %h want 0100", last_bits); end
        repeat (20) @(posedge clk);
        tests_run++; if (dones_seen - d0 != 2) begin tests_failed++; $display("FAIL q_done_count: got %0d want 2", dones_seen - d0); end
    endtask
`else
    task automatic test_busy_ignored();
        int d0, f0, n;
        d0 = dones_seen; f0 = frames_seen;
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h40; req_data_i = 8'hC3;
        @(posedge clk); #1; req_i = 1'b0;
        model_mem[7'h40] = 8'hC3;
        repeat (30) @(posedge clk);
        #1;
        tests_run++; if (req_rdy_o !== 1'b0) begin tests_failed++; $display("FAIL busy_rdy: got %b want 0", req_rdy_o); end
        @(negedge clk);
        req_i = 1'b1; req_we_i = 1'b1; req_addr_i = 7'h41; req_data_i = 8'h77;
        repeat (3) @(negedge clk);
        req_i = 1'b0;
        n = 0;
        while (done_o !== 1'b1 && n < LAT + 50) begin @(posedge clk); #1; n++; end
        repeat (LAT + 40) @(posedge clk);
        tests_run++; if (dones_seen - d0 != 1) begin tests_failed++; $display("FAIL busy_done_count: got %0d want 1", dones_seen - d0); end
        tests_run++; if (frames_seen - f0 != 1) begin tests_failed++; $display("FAIL busy_frame_count: got %0d want 1", frames_seen - f0); end
        tests_run++; if (slave_mem[7'h41] !== model_mem[7'h41]) begin tests_failed++; $display("FAIL busy_no_write: got %h want %h", slave_mem[7'h41], model_mem[7'h41]); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) model_mem[i] = init_val(i);
        test_reset();
        test_write_directed();
        test_read_directed();
`ifdef SPI_MASTER_QUEUE_EN
        test_queue();
`else
        test_busy_ignored();
`endif
        test_random();
        test_reset_mid_frame();
        tests_run++; if (idle_sck_bad != 0) begin tests_failed++; $display("FAIL sck_idle: got %0d high samples with ss high want 0", idle_sck_bad); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master that drives the command/data frame format consumed by our SPI-to-Wishbone slave bridge.
- Frame = command byte {we, addr[6:0]} followed by one data byte.
- On reads, the data byte clocks back the register value that the slave fetched during the inter-byte gap.
- Sits on the host/test-controller side: the host issues a register read/write request, this block runs the full SPI frame and returns read data with a done pulse.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period (minimum 2); one bit time = 2*CLK_DIV.
- GAP_CYC, 16, clk cycles ss stays low with sck idle between command byte and data byte. Gives the slave time for latch, bus access and shift-register load; minimum 8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- req_i  in  1  request strobe; sampled when req_rdy_o=1
- req_we_i  in  1  1=write, 0=read
- req_addr_i  in  7  register address
- req_data_i  in  8  write data (ignored for reads)
- req_rdy_o  out  1  request can be accepted this cycle
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse at frame end
- rd_data_o  out  8  last read byte
- spi_sck  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_mosi  out  1  master out, MSB first
- spi_miso  in  1  master in, sampled on sck rising edge
- spi_ss  out  1  slave select, active-low

Behaviour:
- Reset values: spi_ss=1, spi_sck=0, spi_mosi=0, busy_o=0, done_o=0, rd_data_o=8'h00, req_rdy_o=1. All registered outputs; no combinational path from spi_miso to outputs.
- Accept: req_i=1 and req_rdy_o=1 on a clk edge.
  - Latches cmd={req_we_i, req_addr_i} and wdata=req_data_i (wdata=8'h00 for reads).
  - busy_o=1 from the next cycle.
- FSM states: IDLE -> SS_SETUP -> SHIFT_CMD -> GAP -> SHIFT_DATA -> SS_HOLD -> SS_IDLE -> DONE -> IDLE.
- SS_SETUP:
  - spi_ss=0, sck=0, mosi=cmd[7], held CLK_DIV cycles.
- SHIFT_CMD / SHIFT_DATA (8 bits each):
  - Each bit runs sck high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - Rising edge: capture spi_miso into shift register.
  - Falling edge: advance mosi to the next bit.
  - Bit counter 3 bits; the state ends after the 8th low phase.
- GAP:
  - ss=0, sck=0, mosi=wdata[7] for GAP_CYC cycles.
  - Bits captured during SHIFT_CMD are discarded.
- SHIFT_DATA: mosi shifts out wdata; miso bits are captured.
- SS_HOLD: ss=0, sck=0 for CLK_DIV cycles.
- SS_IDLE: ss=1 for 2*CLK_DIV cycles (ss deassert of at least one bit time between frames).
- DONE: single cycle.
  - done_o=1.
  - For reads, rd_data_o <= captured byte.
  - For writes, rd_data_o is unchanged.
  - busy_o drops the cycle after DONE.
- Latency: done_o asserts 1+CLK_DIV+16*CLK_DIV+GAP_CYC+16*CLK_DIV+CLK_DIV+2*CLK_DIV cycles after the accepting edge (161 for defaults).
- Timing counter: width sized for max(CLK_DIV, GAP_CYC, 2*CLK_DIV); reloads on each state or phase change.
- req_i while not ready: ignored, with no side effects.
- Reset mid-frame: the next edge forces all reset values, aborts the frame, and emits no done_o.
- spi_sck never glitches: it only toggles at phase boundaries and is 0 in every non-shift state.

Optional Feature:
- Macro SPI_MASTER_QUEUE_EN.
- Defined:
  - One-entry pending request register.
  - req_rdy_o = ~pending_valid (not gated by busy).
  - A request accepted while busy is stored.
  - At DONE, the pending request is launched directly: the next cycle enters SS_SETUP and busy_o stays 1. SS_IDLE still guarantees the minimum ss-high time.
  - Reset clears the pending entry.
- Undefined:
  - req_rdy_o = ~busy_o.
  - Requests during a frame are dropped.

Test Plan:
- Write req we=1, addr=7'h12, data=8'hA5 (defaults) -> mosi frame bytes 8'h92 then 8'hA5, MSB first, sampled on sck rise. Check:
  - ss low for exactly 152 cycles.
  - done_o 161 cycles after accept.
  - rd_data_o unchanged at 8'h00.
- Read req addr=7'h05, slave model drives 8'h3C on miso in the data byte -> cmd byte 8'h05, data-byte mosi all 0, rd_data_o=8'h3C at the done_o pulse.
- Timing check: sck high/low = 4 cycles each, 16 sck rising edges per frame, GAP=16 cycles with sck=0, ss high >= 8 cycles before any next frame.
- Reset asserted at cycle 40 of a frame -> next edge ss=1, sck=0, mosi=0, busy_o=0, no done_o. A new request then runs a full clean frame.
- req_i pulsed while busy -> without SPI_MASTER_QUEUE_EN: ignored, exactly one done_o.
- With SPI_MASTER_QUEUE_EN: write 8'h11 then queued read of addr 7'h01 -> two frames, two done_o pulses, ss high >= 8 cycles between frames, req_rdy_o=0 only while the slot is full.
